tx_rate_sequencer: RTL and testbench
====================================

Name: tx_rate_sequencer

Overview:
- Generates the single-cycle clock-enable strobes sam_clk, int_clk and sym_clk from the master clk for the multirate transmit chain.
- Consumers are the 2:1 up-sampler, the pulse-shaping filters and the symbol source.
- Owns start, stop, phase realignment and a zero-stuffing drain that flushes the filters before the chain goes idle.
- One instance per transmit chain; all chain enables come from here.

Parameters:
SAM_DIV, 4, clk cycles per sample period; must be >= 1
UP1, 2, samples per interpolation strobe (up-sampler factor); must be >= 1
UP2, 4, interpolation strobes per symbol strobe; must be >= 1
DRAIN_SAMP, 8, sam_clk pulses issued in DRAIN; must be >= 1

Ports:
clk  in  1  master clock
reset  in  1  synchronous, active-high
start  in  1  level; sampled only in IDLE
stop  in  1  pulse; request graceful stop
sync  in  1  pulse; realign all phase counters
sam_clk  out  1  sample-rate enable strobe
int_clk  out  1  interpolation-rate strobe (up-sampler passes data when high)
sym_clk  out  1  symbol-rate strobe
samp_phase  out  clog2(UP1) (min 1)  sample index within current interpolation period, valid with sam_clk
busy  out  1  high in ALIGN, RUN, DRAIN
draining  out  1  high in DRAIN

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- All outputs are registered.
- Reset values: all strobes 0, samp_phase 0, busy 0, draining 0, state IDLE, all counters 0, stop latch clear.
- Counters:
  - c_cnt: 0..SAM_DIV-1, counts clk cycles.
  - s_cnt: 0..UP1-1, counts sam_clk pulses.
  - i_cnt: 0..UP2-1, counts int_clk pulses.
- Strobe rules in RUN:
  - sam_clk is high in the output cycle following c_cnt==0.
  - int_clk = sam_clk AND s_cnt==0.
  - sym_clk = int_clk AND i_cnt==0.
  - samp_phase = s_cnt of that sample.
  - Strobes are exactly one cycle wide.
  - When SAM_DIV=1, sam_clk is high every cycle.
- States:
  - IDLE: strobes 0. If start is high in cycle T, enter ALIGN (registered busy=1 in T+1).
  - ALIGN: one cycle. Clears all counters and the stop latch, then enters RUN. First sam/int/sym strobes are high together in cycle T+2.
  - RUN:
    - Counters advance; wraps are independent mod-N.
    - A stop pulse sets the stop latch.
    - If the latch is set in the cycle a sym_clk would be issued, that strobe group's int_clk and sym_clk are suppressed. sam_clk still issues, and that pulse counts as drain sample 1. The state moves to DRAIN.
  - DRAIN:
    - sam_clk continues at SAM_DIV spacing.
    - int_clk and sym_clk are held 0, so the up-sampler outputs zeros.
    - After DRAIN_SAMP sam_clk pulses in total, the state returns to IDLE. busy and draining drop in the cycle after the last sam_clk.
- sync in RUN:
  - Next cycle, counters restart from 0 and all three strobes are high together.
  - This holds even if a natural strobe was issued that cycle, giving back-to-back strobes.
  - sync in IDLE, ALIGN or DRAIN is ignored.
- start while busy is ignored. start held high through return to IDLE re-arms immediately, with one IDLE cycle minimum.
- stop and sync in the same cycle: sync realigns the counters and stop is latched. The drain then begins at the resulting immediate sym boundary.
- stop in IDLE, ALIGN or DRAIN is ignored; the latch is cleared in ALIGN.
- Reset mid-operation (any state) returns to the reset values the next cycle; no partial strobe is emitted.

Decomposition:
- Shared package tx_rate_pkg holds:
  - state enum {IDLE, ALIGN, RUN, DRAIN};
  - width helper constants for the counter widths derived from SAM_DIV, UP1, UP2 and DRAIN_SAMP.
- One sub-module, rate_div_counter, is natural: a parameterised mod-N counter with enable, sync-clear and a terminal flag.
  - Instantiated three times, for c_cnt, s_cnt and i_cnt.
  - The drain counter reuses it, with N = DRAIN_SAMP.

Test Plan:
- Defaults, start high at cycle 10:
  - busy=1 at cycle 11.
  - sam/int/sym all high at cycle 12.
  - sam_clk at cycles 12, 16, 20…; int_clk at 12, 20, 28…; sym_clk at 12, 44, 76…
  - samp_phase alternates 0,1.
- Stop pulse at cycle 30:
  - The sym_clk due at cycle 44 is suppressed; int_clk is 0 at 44; sam_clk is 1 at 44.
  - draining=1 from cycle 44.
  - Exactly 8 sam_clk pulses in total (44…72); busy=0 at cycle 73.
- sync at cycle 25 (RUN):
  - All three strobes high at cycle 26.
  - Next sam_clk at cycle 30, next int_clk at 34, next sym_clk at 58.
- SAM_DIV=1, UP1=1, UP2=1:
  - sam_clk, int_clk and sym_clk all high every RUN cycle.
  - A stop ends after DRAIN_SAMP consecutive sam_clk cycles with int_clk=0.
- Reset asserted mid-DRAIN at the 3rd drain sam_clk:
  - Next cycle, all outputs are 0 and busy is 0.
  - A later start restarts the ALIGN→RUN timing exactly as in scenario 1.
- start pulsed while in RUN, and sync/stop pulsed while in IDLE: no state change and no strobes.

Source files
------------

// File: rtl/tx_rate_pkg.sv
// Shared state encoding and counter-width helper for the transmit rate sequencer.
package tx_rate_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ALIGN = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rate_div_counter.sv
// Mod-N counter with enable, synchronous clear and a terminal (count == N-1) flag.
module rate_div_counter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         term
);

    logic [W-1:0] base;
    logic [W-1:0] count_d;

    // clr together with en restarts at 0 and consumes that first count.
    always_comb begin
        base = clr ? '0 : count;
        if (en) begin
            count_d = (base == W'(N - 1)) ? '0 : base + W'(1);
        end else begin
            count_d = base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    assign term = (count == W'(N - 1));

endmodule

// File: rtl/tx_rate_sequencer.sv
// Clock-enable strobe generator for the multirate transmit chain, with start/stop,
// sync realignment and a zero-stuffing drain before returning to idle.
module tx_rate_sequencer
    import tx_rate_pkg::*;
#(
    parameter int unsigned SAM_DIV    = 4,
    parameter int unsigned UP1        = 2,
    parameter int unsigned UP2        = 4,
    parameter int unsigned DRAIN_SAMP = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          sync,
    output logic                          sam_clk,
    output logic                          int_clk,
    output logic                          sym_clk,
    output logic [cnt_width(UP1)-1:0]     samp_phase,
    output logic                          busy,
    output logic                          draining
);

    localparam int unsigned CW = cnt_width(SAM_DIV);
    localparam int unsigned SW = cnt_width(UP1);
    localparam int unsigned IW = cnt_width(UP2);
    localparam int unsigned DW = cnt_width(DRAIN_SAMP);

    state_t        state_q, state_d;
    logic          stop_q, stop_d;
    logic          sam_d, int_d, sym_d;
    logic [SW-1:0] phase_d;
    logic          grp_int, grp_sym, stop_eff;

    logic          c_clr, c_en, c_term;
    logic          s_clr, s_en, s_term;
    logic          i_clr, i_en, i_term;
    logic          d_clr, d_en, d_term;
    logic [CW-1:0] c_cnt;
    logic [SW-1:0] s_cnt;
    logic [IW-1:0] i_cnt;
    logic [DW-1:0] d_cnt;
    logic          unused_flags;

    assign unused_flags = ^{c_term, s_term, i_term, d_cnt};

    rate_div_counter #(.N(SAM_DIV), .W(CW)) u_c_cnt (
        .clk(clk), .reset(reset), .clr(c_clr), .en(c_en), .count(c_cnt), .term(c_term)
    );
    rate_div_counter #(.N(UP1), .W(SW)) u_s_cnt (
        .clk(clk), .reset(reset), .clr(s_clr), .en(s_en), .count(s_cnt), .term(s_term)
    );
    rate_div_counter #(.N(UP2), .W(IW)) u_i_cnt (
        .clk(clk), .reset(reset), .clr(i_clr), .en(i_en), .count(i_cnt), .term(i_term)
    );
    rate_div_counter #(.N(DRAIN_SAMP), .W(DW)) u_d_cnt (
        .clk(clk), .reset(reset), .clr(d_clr), .en(d_en), .count(d_cnt), .term(d_term)
    );

    // Counters hold the position of the next candidate strobe; outputs are decided
    // one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        stop_d   = stop_q;
        sam_d    = 1'b0;
        int_d    = 1'b0;
        sym_d    = 1'b0;
        phase_d  = '0;
        grp_int  = 1'b0;
        grp_sym  = 1'b0;
        stop_eff = stop_q | stop;
        c_clr = 1'b0; c_en = 1'b0;
        s_clr = 1'b0; s_en = 1'b0;
        i_clr = 1'b0; i_en = 1'b0;
        d_clr = 1'b0; d_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ALIGN;
            end
            ST_ALIGN: begin
                stop_d = 1'b0;
                c_clr = 1'b1; c_en = 1'b1;
                s_clr = 1'b1; s_en = 1'b1;
                i_clr = 1'b1; i_en = 1'b1;
                sam_d = 1'b1;
                int_d = 1'b1;
                sym_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) stop_d = 1'b1;
                if (sync) begin
                    c_clr = 1'b1; c_en = 1'b1;
                    s_clr = 1'b1; s_en = 1'b1;
                    i_clr = 1'b1; i_en = 1'b1;
                    sam_d   = 1'b1;
                    grp_int = 1'b1;
                    grp_sym = 1'b1;
                end else begin
                    c_en = 1'b1;
                    if (c_cnt == '0) begin
                        sam_d   = 1'b1;
                        phase_d = s_cnt;
                        s_en    = 1'b1;
                        if (s_cnt == '0) begin
                            grp_int = 1'b1;
                            i_en    = 1'b1;
                            grp_sym = (i_cnt == '0);
                        end
                    end
                end
                // A pending stop turns the next symbol boundary into drain sample 1.
                if (grp_sym && stop_eff) begin
                    state_d = ST_DRAIN;
                    d_clr   = 1'b1;
                end else begin
                    int_d = grp_int;
                    sym_d = grp_sym;
                end
            end
            ST_DRAIN: begin
                c_en = 1'b1;
                if (sam_clk && d_term) begin
                    state_d = ST_IDLE;
                end else if (c_cnt == '0) begin
                    sam_d   = 1'b1;
                    phase_d = s_cnt;
                    s_en    = 1'b1;
                    d_en    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stop_q     <= 1'b0;
            sam_clk    <= 1'b0;
            int_clk    <= 1'b0;
            sym_clk    <= 1'b0;
            samp_phase <= '0;
            busy       <= 1'b0;
            draining   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            sam_clk    <= sam_d;
            int_clk    <= int_d;
            sym_clk    <= sym_d;
            samp_phase <= phase_d;
            busy       <= (state_d != ST_IDLE);
            draining   <= (state_d == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_tx_rate_sequencer.sv
// Directed bench for tx_rate_sequencer: two configurations checked every cycle against a
// timeline model, plus hand-computed cycle expectations.
module tb_tx_rate_sequencer;

    localparam int M_IDLE = 0, M_ALIGN = 1, M_RUN = 2, M_DRAIN = 3;

    typedef struct packed {
        int st;
        int t;
        int drained;
        int phase;
        bit stop_l;
        bit sam;
        bit intc;
        bit sym;
        bit busy;
        bit drn;
    } model_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic sync = 1'b0;

    logic       a_sam, a_int, a_sym, a_busy, a_drn;
    logic [0:0] a_phase;
    logic       b_sam, b_int, b_sym, b_busy, b_drn;
    logic [0:0] b_phase;

    int cyc = -1;
    int vectors = 0;
    int miscompares = 0;
    model_t ma = '0;
    model_t mb = '0;

    always #5 clk = ~clk;

    tx_rate_sequencer #(.SAM_DIV(4), .UP1(2), .UP2(4), .DRAIN_SAMP(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .sync(sync),
        .sam_clk(a_sam), .int_clk(a_int), .sym_clk(a_sym), .samp_phase(a_phase),
        .busy(a_busy), .draining(a_drn)
    );

    tx_rate_sequencer #(.SAM_DIV(1), .UP1(1), .UP2(1), .DRAIN_SAMP(8)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .sync(sync),
        .sam_clk(b_sam), .int_clk(b_int), .sym_clk(b_sym), .samp_phase(b_phase),
        .busy(b_busy), .draining(b_drn)
    );

    // Outputs for the next cycle from time elapsed since the last strobe origin.
    function automatic model_t step(input model_t m, input int sd, input int u1, input int u2,
                                    input int dn, input logic rst, input logic st_in,
                                    input logic stp, input logic syn);
        model_t n;
        int k;
        n = m;
        n.sam = 0; n.intc = 0; n.sym = 0; n.phase = 0;
        if (rst) begin
            n = '0;
            return n;
        end
        case (m.st)
            M_IDLE: if (st_in) n.st = M_ALIGN;
            M_ALIGN: begin
                n.st = M_RUN; n.t = 0; n.stop_l = 0;
                n.sam = 1; n.intc = 1; n.sym = 1;
            end
            M_RUN: begin
                if (stp) n.stop_l = 1;
                n.t = syn ? 0 : m.t + 1;
                if (n.t % sd == 0) begin
                    k = n.t / sd;
                    n.sam = 1;
                    n.phase = k % u1;
                    n.intc = (k % u1 == 0);
                    n.sym = (k % (u1 * u2) == 0);
                end
                if (n.sym && n.stop_l) begin
                    n.intc = 0; n.sym = 0; n.st = M_DRAIN; n.drained = 1;
                end
            end
            default: begin
                n.t = m.t + 1;
                if (m.sam && m.drained == dn) begin
                    n.st = M_IDLE;
                end else if (n.t % sd == 0) begin
                    n.sam = 1;
                    n.drained = m.drained + 1;
                end
            end
        endcase
        n.busy = (n.st != M_IDLE);
        n.drn = (n.st == M_DRAIN);
        return n;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ma <= step(ma, 4, 2, 4, 8, reset, start, stop, sync);
        mb <= step(mb, 1, 1, 1, 8, reset, start, stop, sync);
    end

    task automatic compare_dut(input string nm, input logic s, input logic i, input logic y,
                               input logic [0:0] ph, input logic b, input logic d,
                               input model_t m);
        logic bad;
        vectors++;
        bad = (s !== m.sam) || (i !== m.intc) || (y !== m.sym) || (b !== m.busy) ||
              (d !== m.drn);
        if (m.sam && !m.drn && (ph !== 1'(m.phase))) bad = 1'b1;
        if (bad) begin
            miscompares++;
            $display("FAIL %s cyc=%0d sam/int/sym/phase/busy/drain got %b%b%b %0d %b%b want %b%b%b %0d %b%b",
                     nm, cyc, s, i, y, ph, b, d, m.sam, m.intc, m.sym, m.phase, m.busy, m.drn);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 0) begin
            compare_dut("model_a", a_sam, a_int, a_sym, a_phase, a_busy, a_drn, ma);
            compare_dut("model_b", b_sam, b_int, b_sym, b_phase, b_busy, b_drn, mb);
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        go(3);  reset = 1'b0;
        lit("reset_busy", 32'(a_busy), 0); lit("reset_sam", 32'(a_sam), 0);
        go(10); start = 1'b1;
        go(11); start = 1'b0; lit("align_busy", 32'(a_busy), 1);
        go(12); lit("first_sam", 32'(a_sam), 1); lit("first_int", 32'(a_int), 1);
        lit("first_sym", 32'(a_sym), 1);
        go(16); lit("sam16", 32'(a_sam), 1); lit("phase16", 32'(a_phase), 1);
        lit("int16", 32'(a_int), 0);
        go(20); lit("int20", 32'(a_int), 1); start = 1'b1;
        go(21); start = 1'b0;
        go(30); stop = 1'b1;
        go(31); stop = 1'b0;
        lit("b_drain_sam", 32'(b_sam), 1); lit("b_drain_int", 32'(b_int), 0);
        lit("b_draining", 32'(b_drn), 1);
        go(38); lit("b_last_sam", 32'(b_sam), 1);
        go(39); lit("b_idle", 32'(b_busy), 0);
        go(44); lit("sup_sym", 32'(a_sym), 0); lit("sup_int", 32'(a_int), 0);
        lit("drain1_sam", 32'(a_sam), 1); lit("draining44", 32'(a_drn), 1);
        go(72); lit("drain8_sam", 32'(a_sam), 1);
        go(73); lit("idle73", 32'(a_busy), 0);
        go(80); sync = 1'b1;
        go(81); sync = 1'b0;
        go(82); stop = 1'b1;
        go(83); stop = 1'b0; lit("idle_busy", 32'(a_busy), 0); lit("idle_sam", 32'(a_sam), 0);
        go(100); start = 1'b1;
        go(101); start = 1'b0;
        go(115); sync = 1'b1;
        go(116); sync = 1'b0; lit("sync_sam", 32'(a_sam), 1); lit("sync_sym", 32'(a_sym), 1);
        go(120); lit("sync_next_sam", 32'(a_sam), 1);
        go(124); lit("sync_next_int", 32'(a_int), 1);
        go(148); lit("sync_next_sym", 32'(a_sym), 1);
        go(152); lit("natural_sam", 32'(a_sam), 1); sync = 1'b1;
        go(153); sync = 1'b0; lit("b2b_sam", 32'(a_sam), 1); lit("b2b_sym", 32'(a_sym), 1);
        go(170); stop = 1'b1; sync = 1'b1;
        go(171); stop = 1'b0; sync = 1'b0;
        lit("ss_sam", 32'(a_sam), 1); lit("ss_int", 32'(a_int), 0);
        lit("ss_drain", 32'(a_drn), 1);
        go(200); lit("ss_idle", 32'(a_busy), 0);
        go(220); start = 1'b1;
        go(221); start = 1'b0;
        go(230); stop = 1'b1;
        go(231); stop = 1'b0;
        go(262); lit("drain3_sam", 32'(a_sam), 1); lit("drain3_drn", 32'(a_drn), 1);
        reset = 1'b1;
        go(263); reset = 1'b0;
        lit("rst_busy", 32'(a_busy), 0); lit("rst_sam", 32'(a_sam), 0);
        lit("rst_drn", 32'(a_drn), 0);
        go(280); start = 1'b1;
        go(281); start = 1'b0; lit("restart_busy", 32'(a_busy), 1);
        go(282); lit("restart_sym", 32'(a_sym), 1);
        go(285); start = 1'b1;
        go(300); stop = 1'b1;
        go(301); stop = 1'b0;
        go(343); lit("rearm_idle", 32'(a_busy), 0);
        go(344); lit("rearm_busy", 32'(a_busy), 1);
        go(345); lit("rearm_sym", 32'(a_sym), 1);
        go(351); start = 1'b0;
        go(360); stop = 1'b1;
        go(361); stop = 1'b0;
        go(420);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
